uart_rx_frame_ctrl: RTL

UART receive frame controller that sits directly downstream of, and around, the data_sampling stage.
- Generates the per-bit edge counter and the sample enable that drive the sampler.
- Consumes the sampler's sampled_bit once per bit period and walks the frame: start, data, optional parity, stop.
- Deserializes LSB-first into a parallel word and flags parity and stop errors.
- Emits a one-cycle data_valid pulse for each good frame.

---
 rtl/uart_rx_frame_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller wrapped around an external data_sampling stage.
// Define RX_FRAME_ERR_CNT_EN to add the saturating err_cnt output.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [4:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [4:0]            edge_cnt,
  output logic                  samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
`ifdef RX_FRAME_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [4:0]            prescale_lat;
  logic                  par_en_lat;
  logic                  par_typ_lat;
  logic                  par_mismatch;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  eob;

  assign eob     = (edge_cnt == prescale_lat);
  assign samp_en = (state != IDLE);

  // Frame configuration is frozen at start detection so mid-frame input changes cannot corrupt it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      prescale_lat <= '0;
      par_en_lat   <= 1'b0;
      par_typ_lat  <= 1'b0;
      par_mismatch <= 1'b0;
`ifdef RX_FRAME_ERR_CNT_EN
      err_cnt      <= '0;
`endif
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;

      if (state == IDLE || eob) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state        <= START;
            prescale_lat <= prescale;
            par_en_lat   <= PAR_EN;
            par_typ_lat  <= PAR_TYP;
            par_mismatch <= 1'b0;
          end
        end

        START: begin
          if (eob) begin
            if (sampled_bit) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (eob) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
              state <= par_en_lat ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (eob) begin
            par_mismatch <= (sampled_bit != ((^shift_reg) ^ par_typ_lat));
            state        <= STOP;
          end
        end

        STOP: begin
          if (eob) begin
            stop_error   <= ~sampled_bit;
            parity_error <= par_mismatch;
            if (sampled_bit && !par_mismatch) begin
              data_valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
`ifdef RX_FRAME_ERR_CNT_EN
            if ((!sampled_bit || par_mismatch) && err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
`endif
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
